char_wr_arbiter: RTL and testbench
==================================

CHAR_WR_ARBITER -- requirements
Module: char_wr_arbiter

Interface
REQ-001 SHALL have parameter FILL_DEFAULT, 8'h20, character written by a clear when clr_char_en=0.
REQ-002 SHALL have parameter RAM_DEPTH, 1024, number of character cells (16 rows x 64 columns, address = {row[3:0], col[5:0]}).
REQ-003 SHALL have port clk, input, 1, the single clock; every register is updated on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have ports req0/req1, input, 1 each, write request from requester 0/1.
REQ-006 SHALL have ports adr0/adr1, input, 10 each, cell address; dat0/dat1, input, 8 each, character code.
REQ-007 SHALL have ports ack0/ack1, output, 1 each, one-cycle pulse marking that requester's write as issued.
REQ-008 SHALL have port clr_start, input, 1, pulse requesting a full-screen fill.
REQ-009 SHALL have ports clr_char, input, 8, fill character, and clr_char_en, input, 1, which selects clr_char instead of FILL_DEFAULT.
REQ-010 SHALL have ports busy, output, 1, high while a clear is running, and clr_done, output, 1, one-cycle pulse at the end of a clear.
REQ-011 SHALL have ports ram_Adr, output, 10; ram_Data, output, 8; write_Ram, output, 1; these drive the display RAM write port directly.

Function
REQ-012 SHALL implement the states IDLE, CLEAR and WRITE.
REQ-013 IDLE SHALL go to CLEAR on clr_start; otherwise it SHALL go to WRITE when at least one eligible request is present.
REQ-014 A requester SHALL be eligible when its req is high and its ack is not high in the current cycle; this prevents a double write from a req that is still held.
REQ-015 When only one requester is eligible, that requester SHALL be granted.
REQ-016 When both are eligible, the requester not granted last SHALL be granted (round-robin); after reset, requester 0 SHALL win the first tie.
REQ-017 On a grant edge, the arbiter SHALL register adr/dat of the winner into ram_Adr/ram_Data, and in the following cycle it SHALL drive write_Ram=1 together with the winner's ack=1.
REQ-018 Latency from req sampled to write_Ram/ack high SHALL be exactly 1 cycle.
REQ-019 adr/dat SHALL be held stable by the requester from req high until its ack is seen.
REQ-020 WRITE SHALL last exactly one cycle, then SHALL re-arbitrate as IDLE, so back-to-back alternating writes reach one per cycle.
REQ-021 The same requester SHALL get at most one write every 2 cycles.
REQ-022 Entering CLEAR SHALL latch the fill character: clr_char if clr_char_en=1, else FILL_DEFAULT.
REQ-023 In CLEAR, addresses 0..RAM_DEPTH-1 SHALL be written on consecutive cycles with write_Ram=1, for exactly RAM_DEPTH cycles.
REQ-024 The clear address counter SHALL be 10 bits wide; its wrap from 1023 to 0 SHALL end the clear.
REQ-025 busy SHALL be high from the cycle after clr_start was sampled through the last clear write.
REQ-026 clr_done SHALL pulse in the cycle after the last clear write, and the state SHALL return to IDLE.
REQ-027 clr_start during CLEAR SHALL be ignored (no restart, no queuing).
REQ-028 req0/req1 during CLEAR SHALL be stalled with no ack, and SHALL be served after clr_done in round-robin order.
REQ-029 clr_start sampled in the same cycle as eligible requests SHALL win; the requests SHALL wait.
REQ-030 ack0 and ack1 SHALL never be high together, and neither SHALL be high while busy=1.

Reset
REQ-031 reset_n=0 at a clock edge SHALL force IDLE, write_Ram=0, ack0=ack1=0, busy=0, clr_done=0, ram_Adr=0, ram_Data=0, clear counter=0, last-grant=1 (requester 0 favoured).
REQ-032 Reset during CLEAR or WRITE SHALL abort the operation immediately.
REQ-033 An aborted operation SHALL produce no further write_Ram, and an aborted clear SHALL produce no clr_done.

Structure
REQ-034 A shared package SHALL hold the state encoding (IDLE/CLEAR/WRITE), the RAM_DEPTH/address-width constants and the FILL_DEFAULT value.
REQ-035 The block SHALL be a single module with no sub-modules.
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 Single write: req0=1, adr0=10'h041, dat0=8'h41 -> 1 cycle later write_Ram=1, ram_Adr=10'h041, ram_Data=8'h41, ack0=1 for exactly 1 cycle.
REQ-038 Contention: req0 and req1 held high for 6 cycles, adr0=1/adr1=2 -> write addresses alternate 1,2,1,2,...; first tie after reset goes to requester 0; never two consecutive writes from one requester.
REQ-039 Clear: clr_start with clr_char_en=1, clr_char=8'h2E -> 1024 consecutive writes, addresses 0..1023, all data 8'h2E, busy high 1024 cycles, clr_done one pulse.
REQ-040 Clear vs. request: clr_start and req1 in the same cycle, plus clr_start re-pulsed mid-clear -> exactly one clear of 1024 writes, then ack1 one cycle after clr_done.
REQ-041 Reset mid-clear: reset_n=0 at clear write 500 -> write_Ram=0 and busy=0 from the next cycle, no clr_done; a new clear restarts at address 0 with data 8'h20 when clr_char_en=0.

Source files
------------

// File: rtl/char_wr_arbiter_pkg.sv
// Shared constants, state encoding and grant helper for the character-RAM write arbiter.
package char_wr_arbiter_pkg;

    localparam int         RAM_DEPTH_DEF    = 1024;
    localparam int         ADDR_W           = 10;
    localparam int         DATA_W           = 8;
    localparam logic [7:0] FILL_DEFAULT_DEF = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_e;

    // Returns 1 when requester 1 wins. On a tie the requester not granted last wins.
    function automatic logic pick_winner(input logic elig0, input logic elig1,
                                         input logic last_grant);
        return elig1 && (!elig0 || !last_grant);
    endfunction

endpackage

// File: rtl/char_wr_arbiter.sv
// Two-requester round-robin write arbiter for the character display RAM,
// with a full-screen clear engine that takes priority over requests.
module char_wr_arbiter
    import char_wr_arbiter_pkg::*;
#(
    parameter logic [7:0] FILL_DEFAULT = FILL_DEFAULT_DEF,
    parameter int         RAM_DEPTH    = RAM_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [9:0]  adr0,
    input  logic [9:0]  adr1,
    input  logic [7:0]  dat0,
    input  logic [7:0]  dat1,
    output logic        ack0,
    output logic        ack1,
    input  logic        clr_start,
    input  logic [7:0]  clr_char,
    input  logic        clr_char_en,
    output logic        busy,
    output logic        clr_done,
    output logic [9:0]  ram_Adr,
    output logic [7:0]  ram_Data,
    output logic        write_Ram,
    output logic [1:0]  state_dbg
);

    // Handshake: reqN is held with stable adrN/datN until ackN is seen; ackN is a
    // one-cycle pulse coincident with write_Ram. A req is ignored while its own
    // ack is high, so a still-held req never causes a double write.

    // The counter wraps to this value after the last cell (0 for a 1024-cell screen).
    localparam logic [ADDR_W-1:0] CLR_END = ADDR_W'(RAM_DEPTH);

    arb_state_e        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [7:0]        fill_char;
    logic              last_grant;

    logic              elig0;
    logic              elig1;
    logic              win1;
    logic [9:0]        win_adr;
    logic [7:0]        win_dat;
    logic [7:0]        clr_fill;

    always_comb begin
        elig0    = req0 & ~ack0;
        elig1    = req1 & ~ack1;
        win1     = pick_winner(elig0, elig1, last_grant);
        win_adr  = win1 ? adr1 : adr0;
        win_dat  = win1 ? dat1 : dat0;
        clr_fill = clr_char_en ? clr_char : FILL_DEFAULT;
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            write_Ram  <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            clr_done   <= 1'b0;
            ram_Adr    <= '0;
            ram_Data   <= '0;
            clr_cnt    <= '0;
            fill_char  <= FILL_DEFAULT;
            last_grant <= 1'b1;
        end else begin
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            clr_done <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == CLR_END) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        write_Ram <= 1'b0;
                        clr_done  <= 1'b1;
                        clr_cnt   <= '0;
                    end else begin
                        ram_Adr  <= clr_cnt;
                        ram_Data <= fill_char;
                        clr_cnt  <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    // WRITE is a single cycle and arbitrates exactly like IDLE.
                    if (clr_start) begin
                        state     <= ST_CLEAR;
                        busy      <= 1'b1;
                        write_Ram <= 1'b1;
                        ram_Adr   <= '0;
                        ram_Data  <= clr_fill;
                        fill_char <= clr_fill;
                        clr_cnt   <= 10'd1;
                    end else if (elig0 | elig1) begin
                        state      <= ST_WRITE;
                        write_Ram  <= 1'b1;
                        ram_Adr    <= win_adr;
                        ram_Data   <= win_dat;
                        ack0       <= ~win1;
                        ack1       <= win1;
                        last_grant <= win1;
                    end else begin
                        state     <= ST_IDLE;
                        write_Ram <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_wr_arbiter.sv
// Self-checking bench for char_wr_arbiter: directed scenarios plus randomized
// traffic against a transaction-rule reference model.
module tb_char_wr_arbiter;
    import char_wr_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0, req1;
    logic [9:0] adr0, adr1;
    logic [7:0] dat0, dat1;
    logic       clr_start;
    logic [7:0] clr_char;
    logic       clr_char_en;
    logic       ack0, ack1, busy, clr_done, write_Ram;
    logic [9:0] ram_Adr;
    logic [7:0] ram_Data;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    char_wr_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .adr0(adr0), .adr1(adr1),
        .dat0(dat0), .dat1(dat1), .ack0(ack0), .ack1(ack1),
        .clr_start(clr_start), .clr_char(clr_char), .clr_char_en(clr_char_en),
        .busy(busy), .clr_done(clr_done),
        .ram_Adr(ram_Adr), .ram_Data(ram_Data), .write_Ram(write_Ram),
        .state_dbg(state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req0 = 0; req1 = 0; adr0 = 0; adr1 = 0; dat0 = 0; dat1 = 0;
        clr_start = 0; clr_char = 0; clr_char_en = 0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({write_Ram, ack0, ack1, busy, clr_done} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000", {write_Ram, ack0, ack1, busy, clr_done});
        end
        checks++;
        if ({ram_Adr, ram_Data} !== 18'h0) begin
            errors++;
            $display("FAIL reset_bus got %h/%h want 000/00", ram_Adr, ram_Data);
        end
        checks++;
        if (state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d want %0d", state_dbg, ST_IDLE);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        req0 = 1; adr0 = 10'h041; dat0 = 8'h41;
        tick();
        checks++;
        if ({write_Ram, ack0, ack1, busy, clr_done} !== 5'b11000) begin
            errors++;
            $display("FAIL single_ctrl got %b want 11000", {write_Ram, ack0, ack1, busy, clr_done});
        end
        checks++;
        if ({ram_Adr, ram_Data} !== {10'h041, 8'h41}) begin
            errors++;
            $display("FAIL single_bus got %h/%h want 041/41", ram_Adr, ram_Data);
        end
        req0 = 0;
        tick();
        checks++;
        if ({write_Ram, ack0, ack1} !== 3'b000) begin
            errors++;
            $display("FAIL single_end got %b want 000", {write_Ram, ack0, ack1});
        end
    endtask

    task automatic test_contention();
        logic [9:0] ea;
        logic [1:0] eack;
        do_reset();
        req0 = 1; req1 = 1; adr0 = 10'd1; adr1 = 10'd2; dat0 = 8'hA0; dat1 = 8'hB1;
        for (int i = 0; i < 6; i++) begin
            tick();
            ea   = (i % 2 == 0) ? 10'd1 : 10'd2;
            eack = (i % 2 == 0) ? 2'b10 : 2'b01;
            checks++;
            if ({write_Ram, ack0, ack1, ram_Adr} !== {1'b1, eack, ea}) begin
                errors++;
                $display("FAIL contention_%0d got wr=%b ack=%b%b adr=%0d want wr=1 ack=%b adr=%0d",
                         i, write_Ram, ack0, ack1, ram_Adr, eack, ea);
            end
        end
        req0 = 0; req1 = 0;
        tick();
        checks++;
        if ({write_Ram, ack0, ack1} !== 3'b000) begin
            errors++;
            $display("FAIL contention_end got %b want 000", {write_Ram, ack0, ack1});
        end
    endtask

    task automatic test_clear();
        logic [17:0] e;
        do_reset();
        for (int i = 0; i < 1024; i++) exp_q.push_back({10'(i), 8'h2E});
        clr_start = 1; clr_char_en = 1; clr_char = 8'h2E;
        tick();
        clr_start = 0;
        for (int i = 0; i < 1024; i++) begin
            if (i > 0) tick();
            e = exp_q.pop_front();
            checks++;
            if ({write_Ram, busy, clr_done, ram_Adr, ram_Data} !== {3'b110, e}) begin
                errors++;
                $display("FAIL clear_wr_%0d got wr=%b busy=%b done=%b %h/%h want 110 %h/%h",
                         i, write_Ram, busy, clr_done, ram_Adr, ram_Data, e[17:8], e[7:0]);
            end
        end
        tick();
        checks++;
        if ({write_Ram, busy, clr_done} !== 3'b001) begin
            errors++;
            $display("FAIL clear_done got %b want 001", {write_Ram, busy, clr_done});
        end
        tick();
        checks++;
        if ({write_Ram, busy, clr_done} !== 3'b000) begin
            errors++;
            $display("FAIL clear_after got %b want 000", {write_Ram, busy, clr_done});
        end
    endtask

    task automatic test_clear_vs_req();
        logic [17:0] e;
        for (int i = 0; i < 1024; i++) exp_q.push_back({10'(i), 8'h20});
        clr_start = 1; clr_char_en = 0; clr_char = 8'h77;
        req1 = 1; adr1 = 10'h155; dat1 = 8'h5A;
        tick();
        clr_start = 0;
        for (int i = 0; i < 1024; i++) begin
            if (i > 0) tick();
            e = exp_q.pop_front();
            checks++;
            if ({write_Ram, busy, clr_done, ack0, ack1, ram_Adr, ram_Data} !== {5'b11000, e}) begin
                errors++;
                $display("FAIL clrreq_wr_%0d got wr=%b busy=%b done=%b ack=%b%b %h/%h want 11000 %h/%h",
                         i, write_Ram, busy, clr_done, ack0, ack1, ram_Adr, ram_Data, e[17:8], e[7:0]);
            end
            if (i == 500) clr_start = 1;
            if (i == 501) clr_start = 0;
        end
        tick();
        checks++;
        if ({write_Ram, busy, clr_done, ack1} !== 4'b0010) begin
            errors++;
            $display("FAIL clrreq_done got %b want 0010", {write_Ram, busy, clr_done, ack1});
        end
        tick();
        checks++;
        if ({write_Ram, ack1, busy, ram_Adr, ram_Data} !== {3'b110, 10'h155, 8'h5A}) begin
            errors++;
            $display("FAIL clrreq_ack got wr=%b ack1=%b busy=%b %h/%h want 110 155/5a",
                     write_Ram, ack1, busy, ram_Adr, ram_Data);
        end
        req1 = 0;
        tick();
        checks++;
        if ({write_Ram, busy, ack1} !== 3'b000) begin
            errors++;
            $display("FAIL clrreq_norestart got %b want 000", {write_Ram, busy, ack1});
        end
    endtask

    task automatic test_reset_mid_clear();
        clr_start = 1; clr_char_en = 1; clr_char = 8'h55;
        tick();
        clr_start = 0;
        for (int i = 0; i <= 500; i++) begin
            if (i > 0) tick();
            checks++;
            if ({write_Ram, busy, ram_Adr, ram_Data} !== {2'b11, 10'(i), 8'h55}) begin
                errors++;
                $display("FAIL abort_wr_%0d got wr=%b busy=%b %h/%h want 11 %h/55",
                         i, write_Ram, busy, ram_Adr, ram_Data, 10'(i));
            end
        end
        reset_n = 0;
        tick();
        checks++;
        if ({write_Ram, busy, clr_done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_reset got %b want 000", {write_Ram, busy, clr_done});
        end
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({write_Ram, busy, clr_done} !== 3'b000) begin
                errors++;
                $display("FAIL abort_quiet_%0d got %b want 000", i, {write_Ram, busy, clr_done});
            end
        end
        clr_start = 1; clr_char_en = 0; clr_char = 8'h99;
        tick();
        clr_start = 0;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) tick();
            checks++;
            if ({write_Ram, busy, ram_Adr, ram_Data} !== {2'b11, 10'(i), 8'h20}) begin
                errors++;
                $display("FAIL restart_wr_%0d got wr=%b busy=%b %h/%h want 11 %h/20",
                         i, write_Ram, busy, ram_Adr, ram_Data, 10'(i));
            end
        end
    endtask

    // Reference: a clear runs RAM_DEPTH cells then a done cycle; otherwise each
    // edge grants one eligible requester, the non-last one on a tie.
    task automatic test_random();
        bit         m_clearing = 0;
        int         m_next = 0;
        logic [7:0] m_fill = 8'h20;
        bit         m_last = 1;
        bit         m_ack0 = 0, m_ack1 = 0;
        bit         e0, e1, w;
        bit         x_wr, x_ack0, x_ack1, x_busy, x_done;
        logic [9:0] x_adr;
        logic [7:0] x_dat;
        bit         pend0 = 0, pend1 = 0;
        int         clears = 0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            x_wr = 0; x_ack0 = 0; x_ack1 = 0; x_busy = 0; x_done = 0; x_adr = 0; x_dat = 0;
            if (m_clearing) begin
                if (m_next == 1024) begin
                    m_clearing = 0;
                    x_done = 1;
                end else begin
                    x_wr = 1; x_busy = 1; x_adr = 10'(m_next); x_dat = m_fill;
                    m_next++;
                end
            end else begin
                e0 = req0 && !m_ack0;
                e1 = req1 && !m_ack1;
                if (clr_start) begin
                    m_clearing = 1;
                    m_fill = clr_char_en ? clr_char : 8'h20;
                    m_next = 1;
                    x_wr = 1; x_busy = 1; x_adr = 0; x_dat = m_fill;
                end else if (e0 || e1) begin
                    w = (e0 && e1) ? !m_last : e1;
                    m_last = w;
                    x_wr = 1;
                    x_adr = w ? adr1 : adr0;
                    x_dat = w ? dat1 : dat0;
                    x_ack0 = !w; x_ack1 = w;
                end
            end
            m_ack0 = x_ack0; m_ack1 = x_ack1;
            checks++;
            if ({write_Ram, ack0, ack1, busy, clr_done} !== {x_wr, x_ack0, x_ack1, x_busy, x_done}) begin
                errors++;
                $display("FAIL rand_ctrl_%0d got %b want %b", cyc,
                         {write_Ram, ack0, ack1, busy, clr_done}, {x_wr, x_ack0, x_ack1, x_busy, x_done});
            end
            if (x_wr) begin
                checks++;
                if ({ram_Adr, ram_Data} !== {x_adr, x_dat}) begin
                    errors++;
                    $display("FAIL rand_bus_%0d got %h/%h want %h/%h", cyc, ram_Adr, ram_Data, x_adr, x_dat);
                end
            end
            checks++;
            if ((ack0 && ack1) || ((ack0 || ack1) && busy)) begin
                errors++;
                $display("FAIL rand_excl_%0d got ack=%b%b busy=%b want no overlap", cyc, ack0, ack1, busy);
            end
            if (ack0) begin pend0 = 0; req0 = 0; end
            if (ack1) begin pend1 = 0; req1 = 0; end
            if (!pend0 && $urandom_range(0, 2) == 0) begin
                pend0 = 1; req0 = 1;
                adr0 = 10'($urandom_range(0, 1023)); dat0 = 8'($urandom_range(0, 255));
            end
            if (!pend1 && $urandom_range(0, 2) == 0) begin
                pend1 = 1; req1 = 1;
                adr1 = 10'($urandom_range(0, 1023)); dat1 = 8'($urandom_range(0, 255));
            end
            clr_start = (clears < 2) && ($urandom_range(0, 399) == 0);
            if (clr_start) clears++;
            clr_char_en = 1'($urandom_range(0, 1));
            clr_char = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_clear();
        test_clear_vs_req();
        test_reset_mid_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
